// File: rtl/mpy_seq_pkg.sv
// Shared types and adder-select encodings for the shift-add multiply sequencer.
package mpy_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mpy_state_t;

    localparam logic [1:0] ARIT_PASS = 2'b00;
    localparam logic [1:0] ARIT_ADD  = 2'b01;
    localparam logic [1:0] ARIT_SUB  = 2'b10;

endpackage

// File: rtl/mpy_seq_fsm.sv
// Sequencer control for mpy_seq: state register, iteration counter and BUSY/DONE generation.
module mpy_seq_fsm #(
    parameter int SIZE  = 16,
    parameter int CNT_W = $clog2(SIZE) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic accept,
    output logic last
);
    import mpy_seq_pkg::*;

    mpy_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(SIZE - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // START is only honoured from IDLE; RUN and DONE drop it.
    always_comb begin
        busy   = (state == RUN);
        done   = (state == DONE);
        accept = (state == IDLE) && start;
        last   = (state == RUN) && (cnt == CNT_W'(SIZE - 1));
    end

endmodule

// File: rtl/mpy_seq.sv
// Radix-2 shift-add multiply sequencer driving an external shared adder via the ARIT_* ports.
// Optional two's-complement mode is enabled by defining MPY_SIGNED_EN (adds the SIGNED input).
module mpy_seq #(
    parameter int SIZE = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [SIZE-1:0] OP_A,
    input  logic [SIZE-1:0] OP_B,
`ifdef MPY_SIGNED_EN
    input  logic            SIGNED,
`endif
    output logic            BUSY,
    output logic            DONE,
    output logic [SIZE-1:0] RESLO,
    output logic [SIZE-1:0] RESHI,
    output logic [SIZE-1:0] ARIT_SRC,
    output logic [SIZE-1:0] ARIT_DST,
    output logic [1:0]      ARIT_S,
    output logic            ARIT_CIN,
    input  logic [SIZE-1:0] ARIT_OUT,
    input  logic            ARIT_COUT,
    input  logic            ARIT_V
);
    import mpy_seq_pkg::*;

    logic [SIZE-1:0] acc_hi, acc_lo, mcand;
    logic [SIZE-1:0] nxt_hi, nxt_lo;
    logic            shift_in;
    logic            accept, last, busy, done;
    logic            sgn_mode;

    mpy_seq_fsm #(.SIZE(SIZE)) u_fsm (
        .clk    (CLK),
        .rst    (RST),
        .start  (START),
        .busy   (busy),
        .done   (done),
        .accept (accept),
        .last   (last)
    );

    assign BUSY = busy;
    assign DONE = done;

`ifdef MPY_SIGNED_EN
    always_ff @(posedge CLK) begin
        if (RST)         sgn_mode <= 1'b0;
        else if (accept) sgn_mode <= SIGNED;
    end
`else
    assign sgn_mode = 1'b0;
`endif

    // Signed shift-in is the true sign of the SIZE+1 bit sum (MSB corrected by overflow);
    // the multiplier's sign bit carries negative weight, so its step subtracts.
    always_comb begin
        ARIT_SRC = acc_hi;
        ARIT_DST = mcand;
        ARIT_S   = ARIT_PASS;
        ARIT_CIN = 1'b0;
        shift_in = 1'b0;
        if (busy) begin
            if (acc_lo[0]) begin
                if (sgn_mode && last) begin
                    ARIT_S   = ARIT_SUB;
                    ARIT_CIN = 1'b1;
                    shift_in = ARIT_OUT[SIZE-1] ^ ARIT_V;
                end else begin
                    ARIT_S   = ARIT_ADD;
                    shift_in = sgn_mode ? (ARIT_OUT[SIZE-1] ^ ARIT_V) : ARIT_COUT;
                end
            end else begin
                shift_in = sgn_mode & acc_hi[SIZE-1];
            end
        end
    end

    assign nxt_hi = {shift_in, ARIT_OUT[SIZE-1:1]};
    assign nxt_lo = {ARIT_OUT[0], acc_lo[SIZE-1:1]};

    // Result registers load on the edge into DONE and hold until the next completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            RESHI  <= '0;
            RESLO  <= '0;
        end else if (accept) begin
            acc_hi <= '0;
            acc_lo <= OP_B;
            mcand  <= OP_A;
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (last) begin
                RESHI <= nxt_hi;
                RESLO <= nxt_lo;
            end
        end
    end

endmodule

// File: tb/tb_mpy_seq.sv
// Directed bench for mpy_seq paired with a behavioural model of the shared adder.
module tb_mpy_seq;
    localparam int SIZE = 16;

    logic            CLK = 1'b0;
    logic            RST, START;
    logic [SIZE-1:0] OP_A, OP_B;
`ifdef MPY_SIGNED_EN
    logic            SIGNED;
`endif
    logic            BUSY, DONE;
    logic [SIZE-1:0] RESLO, RESHI, ARIT_SRC, ARIT_DST, ARIT_OUT;
    logic [1:0]      ARIT_S;
    logic            ARIT_CIN, ARIT_COUT, ARIT_V;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mpy_seq #(.SIZE(SIZE)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
`ifdef MPY_SIGNED_EN
        .SIGNED    (SIGNED),
`endif
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESLO     (RESLO),
        .RESHI     (RESHI),
        .ARIT_SRC  (ARIT_SRC),
        .ARIT_DST  (ARIT_DST),
        .ARIT_S    (ARIT_S),
        .ARIT_CIN  (ARIT_CIN),
        .ARIT_OUT  (ARIT_OUT),
        .ARIT_COUT (ARIT_COUT),
        .ARIT_V    (ARIT_V)
    );

    // Shared adder: 01 add, 10 SRC + ~DST + CIN, 00 pass SRC.
    logic [SIZE-1:0] add_b;
    logic [SIZE:0]   add_sum;
    always_comb begin
        add_b     = (ARIT_S == 2'b10) ? ~ARIT_DST : ARIT_DST;
        add_sum   = {1'b0, ARIT_SRC} + {1'b0, add_b} + {{SIZE{1'b0}}, ARIT_CIN};
        ARIT_OUT  = ARIT_SRC;
        ARIT_COUT = 1'b0;
        ARIT_V    = 1'b0;
        if (ARIT_S == 2'b01 || ARIT_S == 2'b10) begin
            ARIT_OUT  = add_sum[SIZE-1:0];
            ARIT_COUT = add_sum[SIZE];
            ARIT_V    = (ARIT_SRC[SIZE-1] == add_b[SIZE-1]) &&
                        (add_sum[SIZE-1] != ARIT_SRC[SIZE-1]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic sgn);
        OP_A  = a;
        OP_B  = b;
`ifdef MPY_SIGNED_EN
        SIGNED = sgn;
`else
        if (sgn) $display("note: signed request in unsigned build");
`endif
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Called in cycle t+1; returns in the DONE cycle (or on timeout).
    task automatic await_done(input string tag, input logic [31:0] exp_prod, input bit inject);
        int k = 1;
        int busy_cnt = 0;
        while (!DONE && k < 40) begin
            if (BUSY) busy_cnt++;
            if (inject && k == 4) begin
                OP_A  = 16'd7;
                OP_B  = 16'd7;
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            tick();
            k++;
        end
        START = 1'b0;
        chk({tag, "_done_lat"}, 64'(k), 64'(SIZE + 1));
        chk({tag, "_busy_cyc"}, 64'(busy_cnt), 64'(SIZE));
        chk({tag, "_prod"}, {32'd0, RESHI, RESLO}, {32'd0, exp_prod});
    endtask

    int extra;

    initial begin
        RST = 1'b1; START = 1'b0; OP_A = '0; OP_B = '0;
`ifdef MPY_SIGNED_EN
        SIGNED = 1'b0;
`endif
        repeat (3) tick();
        RST = 1'b0;
        chk("rst_busy",  64'(BUSY),  64'd0);
        chk("rst_done",  64'(DONE),  64'd0);
        chk("rst_reslo", 64'(RESLO), 64'd0);
        chk("rst_reshi", 64'(RESHI), 64'd0);
        tick();

        start_op(16'd3, 16'd5, 1'b0);
        await_done("u3x5", 32'h0000_000F, 1'b0);
        tick();
        chk("u3x5_pulse", 64'(DONE), 64'd0);
        chk("u3x5_hold", {32'd0, RESHI, RESLO}, 64'h0000_000F);
        chk("u3x5_idle_busy", 64'(BUSY), 64'd0);

        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        await_done("uffff", 32'hFFFE_0001, 1'b0);
        tick();

        start_op(16'h00FF, 16'h0101, 1'b0);
        await_done("ignore", 32'h0000_FFFF, 1'b1);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (DONE) extra++;
        end
        chk("ignore_extra_done", 64'(extra), 64'd0);

        start_op(16'h1234, 16'h5678, 1'b0);
        repeat (7) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_busy",  64'(BUSY),  64'd0);
        chk("abort_done",  64'(DONE),  64'd0);
        chk("abort_reshi", 64'(RESHI), 64'd0);
        chk("abort_reslo", 64'(RESLO), 64'd0);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            if (DONE || BUSY) extra++;
            tick();
        end
        chk("abort_quiet", 64'(extra), 64'd0);

        start_op(16'hABCD, 16'h0002, 1'b0);
        await_done("pre_b2b", 32'h0001_579A, 1'b0);
        OP_A  = 16'h1234;
        OP_B  = 16'h0010;
        START = 1'b1;
        tick();
        chk("b2b_done_cycle_start_ignored", 64'(BUSY), 64'd0);
        tick();
        START = 1'b0;
        await_done("b2b", 32'h0001_2340, 1'b0);
        tick();

`ifdef MPY_SIGNED_EN
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        await_done("s_m1xm1", 32'h0000_0001, 1'b0);
        tick();
        start_op(16'h8000, 16'h0002, 1'b1);
        await_done("s_minx2", 32'hFFFF_0000, 1'b0);
        tick();
        start_op(16'h8000, 16'h8000, 1'b1);
        await_done("s_minxmin", 32'h4000_0000, 1'b0);
        tick();
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        await_done("s0_uffff", 32'hFFFE_0001, 1'b0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpy_seq.md
Name: mpy_seq

Overview:
- Sequential SIZE x SIZE multiply controller for the shared combinational adder (SRC/DST/S/Cin -> ARIT_OUT/Cout/V).
- Radix-2 shift-add: one adder pass per cycle; drives the adder control pins and accumulates the 2*SIZE-bit product.
- Sits beside the ALU as the hardware-multiplier sequencer; the adder instance lives outside and is shared through the ARIT_* ports.

Parameters:
- SIZE, 16, operand width; product is 2*SIZE bits.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- START  input  1  request; accepted only when BUSY=0
- OP_A  input  SIZE  multiplicand, sampled on accepted START
- OP_B  input  SIZE  multiplier, sampled on accepted START
- BUSY  output  1  high while iterating
- DONE  output  1  one-cycle pulse when product is valid
- RESLO  output  SIZE  product bits [SIZE-1:0]
- RESHI  output  SIZE  product bits [2*SIZE-1:SIZE]
- ARIT_SRC  output  SIZE  adder SRC (accumulator high half)
- ARIT_DST  output  SIZE  adder DST (latched multiplicand)
- ARIT_S  output  2  adder select: 01 add, 10 subtract, 00 pass SRC
- ARIT_CIN  output  1  adder carry in
- ARIT_OUT  input  SIZE  adder sum
- ARIT_COUT  input  1  adder carry out
- ARIT_V  input  1  adder overflow

Behaviour:
- Clock/reset: single clock CLK; RST synchronous, active-high.
- Reset values: state=IDLE; BUSY=0, DONE=0, RESLO=0, RESHI=0; internal ACC_HI, ACC_LO, MCAND, CNT all 0.
- Registers: ACC_HI (SIZE), ACC_LO (SIZE, holds multiplier, shifts right), MCAND (SIZE), CNT (log2(SIZE)+1 bits).
- IDLE -> RUN on START:
  - ACC_HI<=0, ACC_LO<=OP_B, MCAND<=OP_A, CNT<=0.
  - START while BUSY=1 is ignored (no queueing).
- RUN, one iteration per cycle:
  - Adder drive: ARIT_SRC=ACC_HI, ARIT_DST=MCAND.
  - If ACC_LO[0]=1: ARIT_S=01, ARIT_CIN=0 (add); else ARIT_S=00, ARIT_CIN=0 (pass).
  - Shift-in bit for unsigned: ARIT_COUT when adding, 0 when passing.
  - Update: {ACC_HI,ACC_LO} <= {shift_in, ARIT_OUT, ACC_LO[SIZE-1:1]}.
  - CNT++; when CNT==SIZE-1 this cycle, next state DONE.
- DONE, one cycle:
  - DONE=1; RESHI/RESLO <= ACC_HI/ACC_LO registered on entry, so they are valid while DONE=1.
  - Next state IDLE.
  - RESHI/RESLO hold until the next completed operation.
- Outside RUN: ARIT_S=00, ARIT_CIN=0, ARIT_SRC=ACC_HI, ARIT_DST=MCAND.
- Timing: START accepted at cycle t; BUSY=1 for cycles t+1..t+SIZE; DONE=1 at t+SIZE+1.
  - START in the DONE cycle is ignored.
  - START in the first IDLE cycle after DONE is accepted.
- RST mid-operation: abort and return to reset values next edge; no DONE pulse.
- Arithmetic: all widths exact; product modulo 2^(2*SIZE); no flags exported.

Optional Feature:
- Macro: MPY_SIGNED_EN
- Enabled:
  - Adds input port SIGNED (1 bit), sampled on START.
  - When SIGNED=1, operands are treated as two's complement.
  - Add iterations: shift-in = ARIT_OUT[SIZE-1] ^ ARIT_V.
  - Pass iterations: shift-in = ACC_HI[SIZE-1].
  - Final iteration (CNT==SIZE-1) with ACC_LO[0]=1: ARIT_S=10, ARIT_CIN=1 (subtract), shift-in = ARIT_OUT[SIZE-1] ^ ARIT_V.
  - SIGNED=0 behaves exactly as unsigned.
- Disabled: no SIGNED port; unsigned only.

Decomposition:
- Shared package:
  - State encoding typedef: IDLE, RUN, DONE.
  - Adder select constants: ARIT_PASS=2'b00, ARIT_ADD=2'b01, ARIT_SUB=2'b10.
- One natural sub-module: mpy_seq_fsm (state register, CNT, BUSY/DONE generation).
- The datapath shift register stays in mpy_seq.
- The adder is not instantiated inside; the bench pairs it with the existing adder block.

Test Plan:
- OP_A=3, OP_B=5, START -> BUSY=1 for 16 cycles; DONE at t+17; RESHI=0x0000, RESLO=0x000F.
- OP_A=0xFFFF, OP_B=0xFFFF, unsigned -> RESHI=0xFFFE, RESLO=0x0001 (checks ARIT_COUT shift-in).
- Second START asserted during BUSY with OP_A=7, OP_B=7 -> ignored; result still from first operands; exactly one DONE pulse.
- RST asserted at cycle t+8 of an operation -> next cycle BUSY=0, DONE=0, RESHI=RESLO=0; no DONE pulse follows.
- MPY_SIGNED_EN: SIGNED=1, OP_A=0xFFFF, OP_B=0xFFFF -> 0x0000_0001; OP_A=0x8000, OP_B=0x0002 -> 0xFFFF_0000; OP_A=0x8000, OP_B=0x8000 -> 0x4000_0000.
- Back-to-back: START in the IDLE cycle right after DONE with OP_A=0x1234, OP_B=0x0010 -> RESHI=0x0001, RESLO=0x2340 after 17 cycles.
